dds_note_player: RTL and testbench

- Parametrised successor to the single-note DDS tone generator.
- Plays a stream of timed note commands: phase-accumulator square-wave output, programmable tuning table, octave shift, per-note duration, articulation gap.
- Sits between a melody source (ROM sequencer or CPU) and the audio pin/buzzer driver; all logic runs in the system clock domain.

---
 rtl/dds_note_player_pkg.sv | 34 +++
 rtl/dds_note_player_if.sv | 30 +++
 rtl/dds_phase_acc.sv | 34 +++
 rtl/dds_note_player.sv | 153 +++++++++++++++
 tb/tb_dds_note_player.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dds_note_player_pkg.sv
// Shared definitions for the DDS note player.
// - FSM state encodings (IDLE, PLAY, GAP) as plain 2-bit constants.
// - Power-on tuning-word defaults.
// - default_k(): returns the default tuning word for a table index.
package dds_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [31:0] K_DEF_1 = 32'd522627;
  localparam logic [31:0] K_DEF_2 = 32'd586652;
  localparam logic [31:0] K_DEF_3 = 32'd658488;
  localparam logic [31:0] K_DEF_4 = 32'd697642;
  localparam logic [31:0] K_DEF_5 = 32'd783062;
  localparam logic [31:0] K_DEF_6 = 32'd878970;
  localparam logic [31:0] K_DEF_7 = 32'd986603;

  // Index 0 is the rest note.
  // Indices above 7 only exist for wider note fields and default to silence.
  function automatic logic [31:0] default_k(input int unsigned idx);
    case (idx)
      1:       return K_DEF_1;
      2:       return K_DEF_2;
      3:       return K_DEF_3;
      4:       return K_DEF_4;
      5:       return K_DEF_5;
      6:       return K_DEF_6;
      7:       return K_DEF_7;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dds_note_player_if.sv
// Command and tuning-table write bus of the DDS note player.
// - master: the melody source (ROM sequencer or CPU).
//   Drives cmd_valid/cmd_note/cmd_oct/cmd_dur and the k_wr_* table write strobe.
//   Receives cmd_ready.
// - slave: the note player.
interface dds_note_player_if #(
  parameter int NOTE_W = 3,
  parameter int OCT_W  = 2,
  parameter int DUR_W  = 8,
  parameter int K_W    = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [NOTE_W-1:0] cmd_note;
  logic [OCT_W-1:0]  cmd_oct;
  logic [DUR_W-1:0]  cmd_dur;
  logic              k_wr_en;
  logic [NOTE_W-1:0] k_wr_addr;
  logic [K_W-1:0]    k_wr_data;

  modport master (
    output cmd_valid, cmd_note, cmd_oct, cmd_dur, k_wr_en, k_wr_addr, k_wr_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_note, cmd_oct, cmd_dur, k_wr_en, k_wr_addr, k_wr_data,
    output cmd_ready
  );
endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator with synchronous clear and enable.
// Ports:
// - clk, rst_n: clock and asynchronous active-low reset.
// - clear: zero the accumulator on the next edge; has priority over enable.
// - enable: add incr on the next edge (modulo 2^ACC_W).
// - incr: per-clock phase increment.
// - phase: current accumulator value.
module dds_phase_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [ACC_W-1:0] incr,
  output logic [ACC_W-1:0] phase
);

  logic [ACC_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear)       phase_d = '0;
    else if (enable) phase_d = phase_q + incr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/dds_note_player.sv
// DDS note player.
// Plays timed note commands as a phase-accumulator square wave, using:
// - a writable tuning table;
// - an octave shift;
// - a per-note duration in ticks;
// - a silent articulation gap after each note.
// Ports:
// - clk, rst: system clock and asynchronous active-low reset.
// - bus: slave side of the command / tuning-table write interface.
// - tone_out: square-wave output (MSB of phase while a non-rest note plays).
// - phase: current accumulator value.
// - busy: a note or its gap is in progress.
// - note_done: one-cycle pulse after a note, including its gap, completes.
module dds_note_player
  import dds_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int K_W      = 24,
  parameter int NOTE_W   = 3,
  parameter int OCT_W    = 2,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 1000000,
  parameter int GAP_CLKS = 50000
) (
  input  logic               clk,
  input  logic               rst,
  dds_note_player_if.slave   bus,
  output logic               tone_out,
  output logic [ACC_W-1:0]   phase,
  output logic               busy,
  output logic               note_done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int K_N    = 2 ** NOTE_W;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  // Where a note goes once its tone part is over (or skipped when dur = 0).
  localparam logic [1:0] ST_POST = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              note_done_q, note_done_d;
  logic [K_W-1:0]    k_q [K_N];
  logic [K_W-1:0]    k_d [K_N];

  logic              acc_clear, acc_en;
  logic [ACC_W-1:0]  incr;

  // The table is read with the latched note, so a write to the playing entry
  // takes effect on the very next increment.
  assign incr = ACC_W'(k_q[note_q]) << oct_q;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    dur_cnt_d   = dur_cnt_q;
    gap_d       = gap_q;
    note_d      = note_q;
    oct_d       = oct_q;
    dur_d       = dur_q;
    note_done_d = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    k_d         = k_q;

    if (bus.k_wr_en) k_d[bus.k_wr_addr] = bus.k_wr_data;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          note_d    = bus.cmd_note;
          oct_d     = bus.cmd_oct;
          dur_d     = bus.cmd_dur;
          tick_d    = '0;
          dur_cnt_d = '0;
          gap_d     = '0;
          acc_clear = 1'b1;
          state_d   = (bus.cmd_dur == '0) ? ST_POST : ST_PLAY;
        end
      end
      ST_PLAY: begin
        acc_en = 1'b1;
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          // dur_q >= 1 here, so the subtraction cannot underflow.
          if (dur_cnt_q == dur_q - DUR_W'(1)) begin
            state_d     = ST_POST;
            gap_d       = '0;
            note_done_d = (ST_POST == ST_IDLE);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d     = ST_IDLE;
          note_done_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      dur_cnt_q   <= '0;
      gap_q       <= '0;
      note_q      <= '0;
      oct_q       <= '0;
      dur_q       <= '0;
      note_done_q <= 1'b0;
      for (int i = 0; i < K_N; i++) k_q[i] <= K_W'(default_k(i));
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      dur_cnt_q   <= dur_cnt_d;
      gap_q       <= gap_d;
      note_q      <= note_d;
      oct_q       <= oct_d;
      dur_q       <= dur_d;
      note_done_q <= note_done_d;
      k_q         <= k_d;
    end
  end

  dds_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk    (clk),
    .rst_n  (rst),
    .clear  (acc_clear),
    .enable (acc_en),
    .incr   (incr),
    .phase  (phase)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign note_done     = note_done_q;
  assign tone_out      = phase[ACC_W-1] & (state_q == ST_PLAY) & (note_q != '0);

endmodule

// File: tb/tb_dds_note_player.sv
module tb_dds_note_player;

  localparam int ACC_W    = 32;
  localparam int K_W      = 24;
  localparam int NOTE_W   = 3;
  localparam int OCT_W    = 2;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int GAP_CLKS = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tone_out, busy, note_done;
  logic [ACC_W-1:0] phase;

  dds_note_player_if #(.NOTE_W(NOTE_W), .OCT_W(OCT_W), .DUR_W(DUR_W), .K_W(K_W)) bus ();

  dds_note_player #(
    .ACC_W(ACC_W), .K_W(K_W), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .DUR_W(DUR_W),
    .TICK_DIV(TICK_DIV), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tone_out  (tone_out),
    .phase     (phase),
    .busy      (busy),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [K_W-1:0] k_model [8];

  typedef struct {
    int             note;
    int             oct;
    int             dur;
    bit             wr;
    int             wr_addr;
    logic [K_W-1:0] wr_data;
    logic [31:0]    exp_phase;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    k_model[0] = 24'd0;      k_model[1] = 24'd522627;
    k_model[2] = 24'd586652; k_model[3] = 24'd658488;
    k_model[4] = 24'd697642; k_model[5] = 24'd783062;
    k_model[6] = 24'd878970; k_model[7] = 24'd986603;
  endfunction

  // Tuning word shifted by the octave, bits past the accumulator dropped.
  function automatic logic [31:0] incr_of(input logic [K_W-1:0] k, input int oct);
    logic [63:0] w;
    w = {40'd0, k} << oct;
    return w[31:0];
  endfunction

  task automatic table_write(input int addr, input logic [K_W-1:0] data);
    bus.k_wr_en   = 1'b1;
    bus.k_wr_addr = 3'(addr);
    bus.k_wr_data = data;
    @(negedge clk);
    bus.k_wr_en   = 1'b0;
    k_model[addr] = data;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic accept(input int note, input int oct, input int dur, input bit hold);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_note  = 3'(note);
    bus.cmd_oct   = 2'(oct);
    bus.cmd_dur   = 8'(dur);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Walks one note from the negedge after acceptance to the note_done sample.
  // - Tone part: dur*TICK_DIV clocks, each adding the increment.
  // - Gap: GAP_CLKS silent clocks.
  // - Then IDLE, with note_done high.
  // If wr_at >= 0, at that sample a table write to the playing entry is
  // launched together with a stray command that must be ignored.
  task automatic watch(input int note, input int oct, input int dur, input int wr_at,
                       input logic [K_W-1:0] wr_val, input string tag,
                       output logic [31:0] fin);
    int          p;
    logic [31:0] exp_ph, old_inc, new_inc;
    p       = dur * TICK_DIV;
    exp_ph  = 32'd0;
    old_inc = incr_of(k_model[note], oct);
    new_inc = incr_of(wr_val, oct);
    for (int j = 0; j <= p + GAP_CLKS; j++) begin
      chk({tag, "_phase"}, phase, exp_ph);
      chk({tag, "_tone"}, tone_out, (j < p) && (note != 0) && exp_ph[31]);
      chk({tag, "_busy"}, busy, j < p + GAP_CLKS);
      chk({tag, "_ready"}, bus.cmd_ready, j == p + GAP_CLKS);
      chk({tag, "_done"}, note_done, j == p + GAP_CLKS);
      if (wr_at >= 0 && j == wr_at) begin
        bus.k_wr_en   = 1'b1;
        bus.k_wr_addr = 3'(note);
        bus.k_wr_data = wr_val;
        bus.cmd_valid = 1'b1;
        bus.cmd_note  = 3'(5);
        bus.cmd_oct   = 2'(0);
        bus.cmd_dur   = 8'(1);
      end
      if (wr_at >= 0 && j == wr_at + 1) begin
        bus.k_wr_en   = 1'b0;
        bus.cmd_valid = 1'b0;
      end
      if (j == p + GAP_CLKS) break;
      @(negedge clk);
      if (j + 1 <= p)
        exp_ph = exp_ph + ((wr_at >= 0 && j + 1 > wr_at + 1) ? new_inc : old_inc);
    end
    if (wr_at >= 0) k_model[note] = wr_val;
    fin = phase;
  endtask

  initial begin
    logic [31:0] fin;
    int          n, o, d;

    bus.cmd_valid = 1'b0;
    bus.cmd_note  = '0;
    bus.cmd_oct   = '0;
    bus.cmd_dur   = '0;
    bus.k_wr_en   = 1'b0;
    bus.k_wr_addr = '0;
    bus.k_wr_data = '0;
    model_reset();

    vecs[0] = '{1, 0, 2, 1'b0, 0, 24'd0,        32'd4181016};
    vecs[1] = '{1, 1, 1, 1'b0, 0, 24'd0,        32'd4181016};
    vecs[2] = '{1, 0, 0, 1'b0, 0, 24'd0,        32'd0};
    vecs[3] = '{0, 0, 2, 1'b0, 0, 24'd0,        32'd0};
    vecs[4] = '{3, 0, 1, 1'b0, 0, 24'd0,        32'd2633952};
    vecs[5] = '{2, 2, 1, 1'b0, 0, 24'd0,        32'd9386432};
    vecs[6] = '{7, 3, 9, 1'b1, 7, 24'hFFFFFF,   32'h1FFFFEE0};
    vecs[7] = '{6, 0, 3, 1'b0, 0, 24'd0,        32'd10547640};

    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tone", tone_out, 0);
    chk("rst_done", note_done, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) table_write(vecs[i].wr_addr, vecs[i].wr_data);
      accept(vecs[i].note, vecs[i].oct, vecs[i].dur, 1'b0);
      watch(vecs[i].note, vecs[i].oct, vecs[i].dur, -1, '0, $sformatf("vec%0d", i), fin);
      chk($sformatf("vec%0d_final", i), fin, vecs[i].exp_phase);
    end

    // Back-to-back: cmd_valid held, so the next command lands the cycle ready rises.
    accept(0, 0, 2, 1'b1);
    bus.cmd_note = 3'(1);
    bus.cmd_oct  = 2'(0);
    bus.cmd_dur  = 8'(1);
    watch(0, 0, 2, -1, '0, "rest_b2b", fin);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    watch(1, 0, 1, -1, '0, "b2b_second", fin);
    chk("b2b_final", fin, 32'd2090508);

    // Live write of the playing entry, with a stray command dropped.
    accept(2, 0, 2, 1'b0);
    watch(2, 0, 2, 2, 24'd1000, "live_wr", fin);
    chk("live_wr_final", fin, 32'd1764956);

    // Randomized notes and table writes against the model.
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0)
        table_write($urandom_range(0, 7), 24'($urandom));
      n = $urandom_range(0, 7);
      o = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      accept(n, o, d, 1'b0);
      watch(n, o, d, -1, '0, $sformatf("rnd%0d", r), fin);
    end

    // Reset in the middle of a note.
    accept(2, 0, 3, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_phase", phase, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tone", tone_out, 0);
    chk("midrst_done", note_done, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    accept(2, 0, 1, 1'b0);
    watch(2, 0, 1, -1, '0, "post_rst", fin);
    chk("post_rst_final", fin, 32'd2346608);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
